bayer_capture_ctrl: RTL and testbench

BAYER_CAPTURE_CTRL -- requirements
Module: bayer_capture_ctrl

---
 rtl/bayer_capture_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bayer_capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_capture_ctrl.sv
// Raw Bayer capture controller: frames the sensor FVAL/LVAL stream, tags each
// accepted pixel with X/Y coordinates and measures line length and frame height.
module bayer_capture_ctrl #(
    parameter int VIDEO_W = 800,
    parameter int VIDEO_H = 600
) (
    input  logic        BAYER_CLK,
    input  logic        reset_n,
    input  logic        CCD_FVAL,
    input  logic        CCD_LVAL,
    input  logic [11:0] CCD_DATA,
    input  logic        START,
    input  logic        STOP,
    output logic [11:0] BAYER_X,
    output logic [11:0] BAYER_Y,
    output logic [11:0] BAYER_DATA,
    output logic        BAYER_VALID,
    output logic [11:0] BAYER_WIDTH,
    output logic [11:0] BAYER_HEIGHT,
    output logic [19:0] FRAME_COUNT,
    output logic        BUSY,
    output logic        ERR_OVERSIZE
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_ACTIVE   = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    localparam logic [11:0] CNT_MAX = 12'hFFF;
    // Limits are one bit wider than the counters so VIDEO_W/H of 4096+ never clip.
    localparam logic [12:0] W_LIM = (VIDEO_W > 4096) ? 13'd4096 : 13'(VIDEO_W);
    localparam logic [12:0] H_LIM = (VIDEO_H > 4096) ? 13'd4096 : 13'(VIDEO_H);
    localparam logic [11:0] W_RST = 12'(VIDEO_W);
    localparam logic [11:0] H_RST = 12'(VIDEO_H);

    state_t      state_q, state_d;
    logic        fval_q, lval_q;
    logic [11:0] x_q, y_q;
    logic [11:0] bx_q, by_q, bdata_q;
    logic        bvalid_q;
    logic [11:0] width_q, height_q;
    logic [19:0] fcount_q;
    logic        busy_q;
    logic        err_q;

    logic        sof, eof, eol;
    logic        capturing;
    logic        pix;
    logic        in_range;
    logic        start_acc;
    logic [11:0] frame_lines;

    always_comb begin
        sof       = CCD_FVAL & ~fval_q;
        eof       = ~CCD_FVAL & fval_q;
        // An LVAL fall only closes a line while the frame was open.
        eol       = ~CCD_LVAL & lval_q & fval_q;
        capturing = (state_q == S_ACTIVE) || (state_q == S_STOPPING);
        pix       = capturing & CCD_FVAL & CCD_LVAL;
        in_range  = ({1'b0, x_q} < W_LIM) && ({1'b0, y_q} < H_LIM);
        start_acc = (state_q == S_IDLE) && START && !STOP;
        // A line still open at EOF counts toward the height, same as EOL-then-EOF.
        if ((x_q != 12'd0) && (y_q != CNT_MAX)) begin
            frame_lines = y_q + 12'd1;
        end else begin
            frame_lines = y_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    state_d = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (sof) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (eof) begin
                    state_d = STOP ? S_IDLE : S_WAIT_SOF;
                end else if (STOP) begin
                    state_d = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (eof) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge BAYER_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            x_q      <= 12'd0;
            y_q      <= 12'd0;
            bx_q     <= 12'd0;
            by_q     <= 12'd0;
            bdata_q  <= 12'd0;
            bvalid_q <= 1'b0;
            width_q  <= W_RST;
            height_q <= H_RST;
            fcount_q <= 20'd0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != S_IDLE);
            fval_q   <= CCD_FVAL;
            lval_q   <= CCD_LVAL;
            bvalid_q <= 1'b0;

            if (start_acc) begin
                err_q <= 1'b0;
            end

            if ((state_q == S_WAIT_SOF) && sof) begin
                x_q <= 12'd0;
                y_q <= 12'd0;
            end

            if (capturing) begin
                if (pix) begin
                    if (in_range) begin
                        bvalid_q <= 1'b1;
                        bx_q     <= x_q;
                        by_q     <= y_q;
                        bdata_q  <= CCD_DATA;
                    end else begin
                        err_q <= 1'b1;
                    end
                    if (x_q != CNT_MAX) begin
                        x_q <= x_q + 12'd1;
                    end
                end

                if (eol && (x_q != 12'd0)) begin
                    width_q <= x_q;
                    x_q     <= 12'd0;
                    if (y_q != CNT_MAX) begin
                        y_q <= y_q + 12'd1;
                    end
                end

                // EOF overrides the counter updates of a coincident EOL.
                if (eof) begin
                    height_q <= frame_lines;
                    fcount_q <= fcount_q + 20'd1;
                    x_q      <= 12'd0;
                    y_q      <= 12'd0;
                end
            end
        end
    end

    assign BAYER_X      = bx_q;
    assign BAYER_Y      = by_q;
    assign BAYER_DATA   = bdata_q;
    assign BAYER_VALID  = bvalid_q;
    assign BAYER_WIDTH  = width_q;
    assign BAYER_HEIGHT = height_q;
    assign FRAME_COUNT  = fcount_q;
    assign BUSY         = busy_q;
    assign ERR_OVERSIZE = err_q;

endmodule

// File: tb/tb_bayer_capture_ctrl.sv
// Directed bench for bayer_capture_ctrl built with VIDEO_W = 8, VIDEO_H = 600.
module tb_bayer_capture_ctrl;

    logic        clk;
    logic        reset_n;
    logic        CCD_FVAL, CCD_LVAL;
    logic [11:0] CCD_DATA;
    logic        START, STOP;
    logic [11:0] BAYER_X, BAYER_Y, BAYER_DATA;
    logic        BAYER_VALID;
    logic [11:0] BAYER_WIDTH, BAYER_HEIGHT;
    logic [19:0] FRAME_COUNT;
    logic        BUSY, ERR_OVERSIZE;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] qx[$];
    logic [11:0] qy[$];
    logic [11:0] qd[$];

    bayer_capture_ctrl #(.VIDEO_W(8), .VIDEO_H(600)) dut (
        .BAYER_CLK   (clk),
        .reset_n     (reset_n),
        .CCD_FVAL    (CCD_FVAL),
        .CCD_LVAL    (CCD_LVAL),
        .CCD_DATA    (CCD_DATA),
        .START       (START),
        .STOP        (STOP),
        .BAYER_X     (BAYER_X),
        .BAYER_Y     (BAYER_Y),
        .BAYER_DATA  (BAYER_DATA),
        .BAYER_VALID (BAYER_VALID),
        .BAYER_WIDTH (BAYER_WIDTH),
        .BAYER_HEIGHT(BAYER_HEIGHT),
        .FRAME_COUNT (FRAME_COUNT),
        .BUSY        (BUSY),
        .ERR_OVERSIZE(ERR_OVERSIZE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of sensor inputs, then log any output pixel 1 ns after the edge.
    task automatic step(input logic f, input logic l, input logic [11:0] d);
        CCD_FVAL = f;
        CCD_LVAL = l;
        CCD_DATA = d;
        @(posedge clk);
        #1;
        if (BAYER_VALID === 1'b1) begin
            qx.push_back(BAYER_X);
            qy.push_back(BAYER_Y);
            qd.push_back(BAYER_DATA);
        end
    endtask

    task automatic clear_q();
        qx.delete();
        qy.delete();
        qd.delete();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step(1'b0, 1'b0, 12'd0);
        START = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1;
        step(1'b0, 1'b0, 12'd0);
        STOP = 1'b0;
    endtask

    // SOF plus full lines; FVAL is left high so the caller closes the frame.
    task automatic frame_body(input int lines, input int pix, input int stop_ln,
                              input int stop_px, input logic [11:0] base);
        step(1'b1, 1'b0, 12'd0);
        step(1'b1, 1'b0, 12'd0);
        for (int ln = 0; ln < lines; ln++) begin
            for (int px = 0; px < pix; px++) begin
                STOP = (ln == stop_ln) && (px == stop_px);
                step(1'b1, 1'b1, base + 12'(ln * 16 + px));
                STOP = 1'b0;
            end
            step(1'b1, 1'b0, 12'd0);
            step(1'b1, 1'b0, 12'd0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        CCD_FVAL = 1'b0;
        CCD_LVAL = 1'b0;
        CCD_DATA = 12'd0;
        START    = 1'b0;
        STOP     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x",      32'(BAYER_X),      32'd0);
        chk("rst_y",      32'(BAYER_Y),      32'd0);
        chk("rst_data",   32'(BAYER_DATA),   32'd0);
        chk("rst_valid",  32'(BAYER_VALID),  32'd0);
        chk("rst_width",  32'(BAYER_WIDTH),  32'd8);
        chk("rst_height", 32'(BAYER_HEIGHT), 32'd600);
        chk("rst_fcount", 32'(FRAME_COUNT),  32'd0);
        chk("rst_busy",   32'(BUSY),         32'd0);
        chk("rst_err",    32'(ERR_OVERSIZE), 32'd0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 12'd0);
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Basic 4-line x 6-pixel frame
        pulse_start();
        chk("A_busy_wait", 32'(BUSY), 32'd1);
        clear_q();
        frame_body(4, 6, -1, -1, 12'h100);
        step(1'b0, 1'b0, 12'd0);
        chk("A_npix", 32'(qx.size()), 32'd24);
        for (int i = 0; i < 24; i++) begin
            if (i < qx.size()) begin
                chk("A_x", 32'(qx[i]), 32'(i % 6));
                chk("A_y", 32'(qy[i]), 32'(i / 6));
                chk("A_data", 32'(qd[i]), 32'(12'h100 + 12'((i / 6) * 16 + (i % 6))));
            end
        end
        chk("A_width",  32'(BAYER_WIDTH),  32'd6);
        chk("A_height", 32'(BAYER_HEIGHT), 32'd4);
        chk("A_fcount", 32'(FRAME_COUNT),  32'd1);
        chk("A_busy",   32'(BUSY),         32'd1);
        chk("A_hold_valid", 32'(BAYER_VALID), 32'd0);
        chk("A_hold_x",     32'(BAYER_X),     32'd5);
        chk("A_hold_y",     32'(BAYER_Y),     32'd3);
        chk("A_hold_data",  32'(BAYER_DATA),  32'h135);

        // STOP in WAIT_SOF, then START while FVAL is already high
        pulse_stop();
        chk("B_busy_idle", 32'(BUSY), 32'd0);
        step(1'b1, 1'b0, 12'd0);
        step(1'b1, 1'b0, 12'd0);
        START = 1'b1;
        step(1'b1, 1'b0, 12'd0);
        START = 1'b0;
        chk("B_busy_wait", 32'(BUSY), 32'd1);
        clear_q();
        for (int p = 0; p < 3; p++) step(1'b1, 1'b1, 12'h0AA);
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        chk("B_no_valid", 32'(qx.size()), 32'd0);
        chk("B_fcount_hold", 32'(FRAME_COUNT), 32'd1);
        frame_body(2, 3, -1, -1, 12'h200);
        step(1'b0, 1'b0, 12'd0);
        chk("B_npix", 32'(qx.size()), 32'd6);
        if (qx.size() == 6) begin
            chk("B_first_x", 32'(qx[0]), 32'd0);
            chk("B_first_y", 32'(qy[0]), 32'd0);
            chk("B_first_d", 32'(qd[0]), 32'h200);
            chk("B_last_x",  32'(qx[5]), 32'd2);
            chk("B_last_y",  32'(qy[5]), 32'd1);
        end
        chk("B_fcount", 32'(FRAME_COUNT),  32'd2);
        chk("B_width",  32'(BAYER_WIDTH),  32'd3);
        chk("B_height", 32'(BAYER_HEIGHT), 32'd2);

        // STOP during line 2 lets the frame finish, then drops to IDLE
        clear_q();
        frame_body(4, 4, 1, 1, 12'h300);
        chk("C_busy_before_eof", 32'(BUSY), 32'd1);
        step(1'b0, 1'b0, 12'd0);
        chk("C_busy_after_eof", 32'(BUSY), 32'd0);
        chk("C_fcount", 32'(FRAME_COUNT),  32'd3);
        chk("C_height", 32'(BAYER_HEIGHT), 32'd4);
        chk("C_npix",   32'(qx.size()),    32'd16);
        if (qx.size() == 16) begin
            chk("C_last_x", 32'(qx[15]), 32'd3);
            chk("C_last_y", 32'(qy[15]), 32'd3);
            chk("C_last_d", 32'(qd[15]), 32'h333);
        end
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        chk("C_stay_idle", 32'(BUSY), 32'd0);

        // 10-pixel lines against VIDEO_W = 8
        pulse_start();
        chk("D_err_clear", 32'(ERR_OVERSIZE), 32'd0);
        clear_q();
        frame_body(2, 10, -1, -1, 12'h400);
        step(1'b0, 1'b0, 12'd0);
        chk("D_npix", 32'(qx.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < qx.size()) begin
                chk("D_x", 32'(qx[i]), 32'(i % 8));
                chk("D_y", 32'(qy[i]), 32'(i / 8));
            end
        end
        chk("D_err",    32'(ERR_OVERSIZE), 32'd1);
        chk("D_width",  32'(BAYER_WIDTH),  32'd10);
        chk("D_height", 32'(BAYER_HEIGHT), 32'd2);
        chk("D_fcount", 32'(FRAME_COUNT),  32'd4);
        pulse_stop();
        chk("D_err_sticky", 32'(ERR_OVERSIZE), 32'd1);
        pulse_start();
        chk("D_err_cleared", 32'(ERR_OVERSIZE), 32'd0);
        chk("D_busy", 32'(BUSY), 32'd1);

        // START and STOP together in IDLE
        pulse_stop();
        START = 1'b1;
        STOP  = 1'b1;
        step(1'b0, 1'b0, 12'd0);
        START = 1'b0;
        STOP  = 1'b0;
        chk("E_busy", 32'(BUSY), 32'd0);
        step(1'b0, 1'b0, 12'd0);
        chk("E_busy_hold", 32'(BUSY), 32'd0);
        clear_q();
        frame_body(1, 2, -1, -1, 12'h500);
        step(1'b0, 1'b0, 12'd0);
        chk("E_no_valid", 32'(qx.size()), 32'd0);
        chk("E_fcount", 32'(FRAME_COUNT), 32'd4);

        // Asynchronous reset at pixel 3 of the second line
        pulse_start();
        step(1'b1, 1'b0, 12'd0);
        step(1'b1, 1'b0, 12'd0);
        for (int p = 0; p < 3; p++) step(1'b1, 1'b1, 12'(12'h600 + p));
        step(1'b1, 1'b0, 12'd0);
        step(1'b1, 1'b0, 12'd0);
        for (int p = 0; p < 3; p++) step(1'b1, 1'b1, 12'(12'h610 + p));
        chk("F_pre_valid", 32'(BAYER_VALID), 32'd1);
        chk("F_pre_width", 32'(BAYER_WIDTH), 32'd3);
        CCD_FVAL = 1'b1;
        CCD_LVAL = 1'b1;
        CCD_DATA = 12'h613;
        #2;
        reset_n = 1'b0;
        #1;
        chk("F_valid",  32'(BAYER_VALID),  32'd0);
        chk("F_x",      32'(BAYER_X),      32'd0);
        chk("F_y",      32'(BAYER_Y),      32'd0);
        chk("F_data",   32'(BAYER_DATA),   32'd0);
        chk("F_width",  32'(BAYER_WIDTH),  32'd8);
        chk("F_height", 32'(BAYER_HEIGHT), 32'd600);
        chk("F_fcount", 32'(FRAME_COUNT),  32'd0);
        chk("F_busy",   32'(BUSY),         32'd0);
        chk("F_err",    32'(ERR_OVERSIZE), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        clear_q();
        step(1'b1, 1'b1, 12'h614);
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        chk("F_post_fcount", 32'(FRAME_COUNT), 32'd0);
        chk("F_post_busy",   32'(BUSY),        32'd0);
        chk("F_post_valid",  32'(qx.size()),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
